meas_scheduler: RTL and testbench

Measurement sequencer for the 8-channel frequency counter. It steps round-robin through the channels enabled in `chan_mask` and drives the channel select, counter clear and gate window for each one. After each gate window it streams a two-byte result frame (header, count) to the UART sender over a valid/ready handshake. It sits between the timebase, the counter and the UART sender, and replaces free-running channel rotation with mask-controlled scheduling.

---
 rtl/meas_scheduler.sv | 167 ++++++++++++++++
 tb/tb_meas_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_scheduler.sv
// meas_scheduler: mask-driven round-robin sequencer for the 8-channel
// frequency counter; emits a {header, count} frame per gate window.
module meas_scheduler #(
  parameter int unsigned GATE_TICKS = 4,
  parameter logic [3:0]  HDR_TAG    = 4'hA
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] chan_mask,
  input  logic [7:0] count_in,
  input  logic       tx_ready,
  output logic [2:0] sel,
  output logic       cnt_clr,
  output logic       gate,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       round_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_GATE,
    S_LATCH,
    S_HDR,
    S_CNT
  } state_t;

  state_t     r_state;
  state_t     w_state;
  logic [2:0] r_sel;
  logic [2:0] w_sel;
  logic [2:0] r_last;
  logic [2:0] w_last;
  logic [3:0] r_tcnt;
  logic [3:0] w_tcnt;
  logic [7:0] r_result;
  logic [7:0] w_result;
  logic [7:0] r_tx_data;
  logic [7:0] w_tx_data;
  logic       r_cnt_clr;
  logic       r_gate;
  logic       r_tx_valid;
  logic       w_hs;
  logic [2:0] w_idx;
  logic [2:0] w_pick;
  logic       w_found;
  logic [2:0] w_top;
  logic       w_any;

  // Circular search for the next enabled channel after the last one served.
  always_comb begin
    w_idx   = '0;
    w_pick  = r_last;
    w_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      w_idx = r_last + 3'(i);
      if (!w_found && chan_mask[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_top = '0;
    for (int i = 0; i < 8; i++) begin
      if (chan_mask[i]) begin
        w_top = 3'(i);
      end
    end
  end

  assign w_any = |chan_mask;
  assign w_hs  = r_tx_valid & tx_ready;

  always_comb begin
    w_state   = r_state;
    w_sel     = r_sel;
    w_last    = r_last;
    w_tcnt    = r_tcnt;
    w_result  = r_result;
    w_tx_data = r_tx_data;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_sel   = w_pick;
          w_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state = S_ARM;
      end
      S_ARM: begin
        if (tick) begin
          w_tcnt  = '0;
          w_state = S_GATE;
        end
      end
      S_GATE: begin
        if (tick) begin
          w_tcnt = r_tcnt + 4'd1;
          if (w_tcnt == 4'(GATE_TICKS)) begin
            w_state = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        // Counter has had a full cycle to settle after gate fell.
        w_result  = count_in;
        w_tx_data = {HDR_TAG, 1'b0, r_sel};
        w_state   = S_HDR;
      end
      S_HDR: begin
        if (w_hs) begin
          w_tx_data = r_result;
          w_state   = S_CNT;
        end
      end
      S_CNT: begin
        if (w_hs) begin
          w_last  = r_sel;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_last     <= 3'd7;
      r_tcnt     <= '0;
      r_result   <= '0;
      r_tx_data  <= '0;
      r_cnt_clr  <= 1'b0;
      r_gate     <= 1'b0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sel      <= w_sel;
      r_last     <= w_last;
      r_tcnt     <= w_tcnt;
      r_result   <= w_result;
      r_tx_data  <= w_tx_data;
      r_cnt_clr  <= (w_state == S_CLEAR);
      r_gate     <= (w_state == S_GATE);
      r_tx_valid <= (w_state == S_HDR) || (w_state == S_CNT);
    end
  end

  assign sel      = r_sel;
  assign cnt_clr  = r_cnt_clr;
  assign gate     = r_gate;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;

  // Flags the count-byte handshake of the top enabled channel.
  assign round_done = w_hs & (r_state == S_CNT) & w_any & (r_sel == w_top);

endmodule

// File: tb/tb_meas_scheduler.sv
// Bench for meas_scheduler: directed frame table, corner sequences and
// a randomized run against a frame-level reference model.
module tb_meas_scheduler;

  localparam int GT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [7:0] chan_mask;
  logic [7:0] count_in;
  logic       tx_ready;
  logic [2:0] sel;
  logic       cnt_clr;
  logic       gate;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       round_done;

  meas_scheduler #(.GATE_TICKS(GT), .HDR_TAG(4'hA)) dut (
    .clk_in    (clk),
    .reset     (rst_n),
    .tick      (tick),
    .chan_mask (chan_mask),
    .count_in  (count_in),
    .tx_ready  (tx_ready),
    .sel       (sel),
    .cnt_clr   (cnt_clr),
    .gate      (gate),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  int   tick_mode = 0;
  logic gen_tick  = 1'b0;
  logic man_tick  = 1'b0;
  int   tcnt      = 0;

  assign tick = (tick_mode == 3) ? man_tick : gen_tick;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        1: begin
          tcnt     = (tcnt + 1) % 16;
          gen_tick = (tcnt == 0);
        end
        2: gen_tick = ($urandom_range(0, 3) == 0);
        default: gen_tick = 1'b0;
      endcase
    end
  end

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] next_en(input logic [2:0] last,
                                         input logic [7:0] m);
    int k;
    for (int i = 1; i <= 8; i++) begin
      k = (int'(last) + i) % 8;
      if (m[k]) return 3'(k);
    end
    return last;
  endfunction

  function automatic logic [2:0] top_of(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  // what: 0 cnt_clr, 1 gate, 2 gate low, 3 tx_valid, 4 handshake
  task automatic wait_for(input int what, output bit ok);
    int  n;
    bit  c;
    n = 0;
    forever begin
      case (what)
        0:       c = cnt_clr;
        1:       c = gate;
        2:       c = !gate;
        3:       c = tx_valid;
        default: c = tx_valid && tx_ready;
      endcase
      if (c || n >= 3000) break;
      @(negedge clk);
      n++;
    end
    ok = c;
  endtask

  task automatic run_frame(input logic [7:0] mid,
                           output logic [7:0] hdr,
                           output logic [7:0] cnt,
                           output logic rd,
                           output int glen,
                           output bit ok);
    bit o1, o2, o3, o4, o5;
    glen = 0;
    wait_for(0, o1);
    wait_for(1, o2);
    if (mid != 8'h00) chan_mask = mid;
    while (gate && glen < 3000) begin
      glen++;
      @(negedge clk);
    end
    wait_for(4, o3);
    hdr = tx_data;
    @(negedge clk);
    wait_for(4, o4);
    cnt = tx_data;
    rd  = round_done;
    o5  = !gate;
    ok  = o1 && o2 && o3 && o4 && o5;
  endtask

  typedef struct {
    logic [7:0] mask;
    logic [7:0] mid;
    logic [7:0] cnt;
    logic [7:0] exp_hdr;
    logic       exp_rd;
  } vec_t;

  vec_t tbl[11];

  logic [7:0] h, c;
  logic       r;
  int         gl;
  bit         ok, bad;

  // random-phase model state
  logic [7:0] q[$];
  logic [2:0] m_last, m_cur, exp_ch;
  logic [7:0] mask_prev, pend_mask, prev_data, exp_b;
  bit         mask_pend, prev_gate, prev_tick, prev_valid, prev_ready;
  bit         arm_on, byte_cnt, exp_rd;
  int         arm_ticks, g_ticks, frames;

  initial begin
    tbl[0]  = '{8'h05, 8'h00, 8'h3C, 8'hA0, 1'b0};
    tbl[1]  = '{8'h05, 8'h00, 8'h3C, 8'hA2, 1'b1};
    tbl[2]  = '{8'h05, 8'h00, 8'h3C, 8'hA0, 1'b0};
    tbl[3]  = '{8'h05, 8'h00, 8'h3C, 8'hA2, 1'b1};
    tbl[4]  = '{8'h80, 8'h00, 8'h55, 8'hA7, 1'b1};
    tbl[5]  = '{8'h80, 8'h00, 8'h66, 8'hA7, 1'b1};
    tbl[6]  = '{8'h80, 8'h03, 8'h77, 8'hA7, 1'b0};
    tbl[7]  = '{8'h03, 8'h00, 8'h88, 8'hA0, 1'b0};
    tbl[8]  = '{8'h03, 8'h00, 8'h99, 8'hA1, 1'b1};
    tbl[9]  = '{8'h42, 8'h00, 8'h12, 8'hA6, 1'b1};
    tbl[10] = '{8'h42, 8'h00, 8'h34, 8'hA1, 1'b0};

    // Reset with random inputs
    rst_n     = 1'b0;
    tick_mode = 2;
    chan_mask = 8'h00;
    count_in  = 8'h00;
    tx_ready  = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chan_mask = 8'($urandom);
      count_in  = 8'($urandom);
      tx_ready  = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_sel", int'(sel), 0);
    chk("rst_clr", int'(cnt_clr), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_rd", int'(round_done), 0);

    chan_mask = 8'h00;
    rst_n     = 1'b1;
    bad       = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cnt_clr || gate || tx_valid) bad = 1;
    end
    chk("idle_quiet", int'(bad), 0);

    // Frame table with periodic ticks
    tick_mode = 1;
    tx_ready  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      chan_mask = tbl[i].mask;
      count_in  = tbl[i].cnt;
      run_frame(tbl[i].mid, h, c, r, gl, ok);
      chk($sformatf("v%0d_done", i), int'(ok), 1);
      chk($sformatf("v%0d_hdr", i), int'(h), int'(tbl[i].exp_hdr));
      chk($sformatf("v%0d_cnt", i), int'(c), int'(tbl[i].cnt));
      chk($sformatf("v%0d_rd", i), int'(r), int'(tbl[i].exp_rd));
      chk($sformatf("v%0d_glen", i), gl, GT * 16);
    end

    // Reset in the middle of a gate window
    chan_mask = 8'h30;
    wait_for(1, ok);
    chk("mr_gate_seen", int'(ok), 1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_gate_drop", int'(gate), 0);
    chk("mr_valid", int'(tx_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h00, h, c, r, gl, ok);
    chk("mr_done", int'(ok), 1);
    chk("mr_hdr", int'(h), 8'hA4);
    chk("mr_rd", int'(r), 0);
    run_frame(8'h00, h, c, r, gl, ok);
    chk("mr_hdr2", int'(h), 8'hA5);
    chk("mr_rd2", int'(r), 1);

    // Backpressure on the header byte
    @(negedge clk);
    chan_mask = 8'h01;
    tx_ready  = 1'b0;
    count_in  = 8'h5A;
    wait_for(3, ok);
    chk("bp_valid_seen", int'(ok), 1);
    bad = 0;
    repeat (20) begin
      if (!(tx_valid && tx_data == 8'hA0)) bad = 1;
      @(negedge clk);
    end
    chk("bp_hold", int'(bad), 0);
    chk("bp_hdr", int'(tx_data), 8'hA0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_cnt_valid", int'(tx_valid), 1);
    chk("bp_cnt", int'(tx_data), 8'h5A);
    chk("bp_rd", int'(round_done), 1);

    // Latch point and a tick landing in LATCH
    count_in = 8'h10;
    wait_for(0, ok);
    chk("lp_clr", int'(ok), 1);
    wait_for(1, ok);
    wait_for(2, ok);
    chk("lp_gate_fall", int'(ok), 1);
    count_in  = 8'h11;
    tick_mode = 3;
    man_tick  = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    wait_for(4, ok);
    chk("lp_hdr", int'(tx_data), 8'hA0);
    @(negedge clk);
    wait_for(4, ok);
    chk("lp_cnt", int'(tx_data), 8'h11);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (gate) bad = 1;
    end
    chk("lp_no_window", int'(bad), 0);

    // Randomized run against the frame-level model
    rst_n     = 1'b0;
    tick_mode = 2;
    chan_mask = 8'($urandom_range(1, 255));
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    q.delete();
    m_last     = 3'd7;
    m_cur      = 3'd0;
    mask_prev  = chan_mask;
    mask_pend  = 0;
    pend_mask  = 8'h00;
    prev_gate  = 0;
    prev_tick  = 0;
    prev_valid = 0;
    prev_ready = 0;
    prev_data  = 8'h00;
    arm_on     = 0;
    byte_cnt   = 0;
    arm_ticks  = 0;
    g_ticks    = 0;
    frames     = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(0, 3) != 0);
      count_in = 8'($urandom);
      if (mask_pend) begin
        chan_mask = pend_mask;
        mask_pend = 0;
      end
      @(negedge clk);
      if (cnt_clr) begin
        exp_ch = next_en(m_last, mask_prev);
        chk("rnd_sel", int'(sel), int'(exp_ch));
        m_cur = exp_ch;
        q.push_back({4'hA, 1'b0, exp_ch});
        arm_on    = 1;
        arm_ticks = 0;
      end
      if (gate && !prev_gate) begin
        chk("rnd_arm", int'(arm_on && arm_ticks == 1 && prev_tick), 1);
        arm_on  = 0;
        g_ticks = 0;
      end
      if (!gate && prev_gate) begin
        chk("rnd_gate_ticks", g_ticks, GT);
        chk("rnd_gate_end", int'(prev_tick), 1);
        q.push_back(count_in);
      end
      if (arm_on && !cnt_clr && tick) arm_ticks++;
      if (gate && tick) g_ticks++;
      if (prev_valid && !prev_ready) begin
        chk("rnd_hold", int'({tx_valid, tx_data}), int'({1'b1, prev_data}));
      end
      exp_rd = 0;
      if (tx_valid && tx_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_byte", int'(tx_data), -1);
        end else begin
          exp_b = q.pop_front();
          chk("rnd_byte", int'(tx_data), int'(exp_b));
        end
        if (byte_cnt) begin
          m_last = m_cur;
          exp_rd = (m_cur == top_of(chan_mask));
          frames++;
        end
        byte_cnt = !byte_cnt;
      end
      chk("rnd_rd", int'(round_done), int'(exp_rd));
      if (gate && !mask_pend && $urandom_range(0, 15) == 0) begin
        pend_mask = 8'($urandom_range(1, 255));
        mask_pend = 1;
      end
      prev_gate  = gate;
      prev_tick  = tick;
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      mask_prev  = chan_mask;
    end
    chk("rnd_frames", int'(frames >= 100), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
